// File: rtl/ppfifo_write_arbiter_if.sv
// ppfifo_write_arbiter_if
//   Groups every signal between the write arbiter, its two block writers and
//   the downstream Ping Pong FIFO write controller.
//   slave  : the arbiter's view (takes requests/strobes, drives grants and FIFO side)
//   master : the environment's view (writers plus the PPFIFO write controller)
//
// Handshake semantics:
//   i_req[n] is a level held by writer n until o_gnt[n] rises. While granted,
//   i_stb[n] qualifies i_data<n> for exactly the cycle it is high (there is no
//   backpressure), and a single-cycle i_done[n] ends the block. o_ppfifo_stb
//   likewise qualifies o_ppfifo_data for one cycle towards the PPFIFO.
interface ppfifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            i_req;
  logic [1:0]            o_gnt;
  logic [23:0]           o_req_size;
  logic [1:0]            i_stb;
  logic [DATA_WIDTH-1:0] i_data0;
  logic [DATA_WIDTH-1:0] i_data1;
  logic [1:0]            i_done;
  logic                  o_overflow;
  logic                  o_ppfifo_clk;
  logic [1:0]            i_ppfifo_rdy;
  logic [1:0]            o_ppfifo_act;
  logic [23:0]           i_ppfifo_size;
  logic                  o_ppfifo_stb;
  logic [DATA_WIDTH-1:0] o_ppfifo_data;

  modport slave (
    input  i_req, i_stb, i_data0, i_data1, i_done, i_ppfifo_rdy, i_ppfifo_size,
    output o_gnt, o_req_size, o_overflow, o_ppfifo_clk, o_ppfifo_act,
           o_ppfifo_stb, o_ppfifo_data
  );

  modport master (
    output i_req, i_stb, i_data0, i_data1, i_done, i_ppfifo_rdy, i_ppfifo_size,
    input  o_gnt, o_req_size, o_overflow, o_ppfifo_clk, o_ppfifo_act,
           o_ppfifo_stb, o_ppfifo_data
  );
endinterface

// File: rtl/ppfifo_write_arbiter.sv
// ppfifo_write_arbiter
//   Shares one Ping Pong FIFO write port between two block-oriented writers.
//   Acquires a ready downstream buffer, grants it to one writer for one block,
//   forwards that writer's strobes with a fixed one-cycle latency, releases the
//   buffer, then re-arbitrates round-robin.
// Ports
//   clk          system clock (also forwarded as bus.o_ppfifo_clk)
//   rst          synchronous, active-high reset
//   bus          ppfifo_write_arbiter_if.slave: writer and PPFIFO signals
//   o_dbg_state  current FSM state (0 idle, 1 grant, 2 release)
//   o_dbg_rr     round-robin pointer: requester that has priority next
module ppfifo_write_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ppfifo_write_arbiter_if.slave        bus,
  output logic [1:0]                   o_dbg_state,
  output logic                         o_dbg_rr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  sel_q, sel_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            act_q, act_d;
  logic [23:0]           size_q, size_d;
  logic [23:0]           count_q, count_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
      act_q   <= 2'b00;
      size_q  <= 24'd0;
      count_q <= 24'd0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      act_q   <= act_d;
      size_q  <= size_d;
      count_q <= count_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    act_d   = act_q;
    size_d  = size_q;
    count_d = count_q;
    stb_d   = 1'b0;   // strobe and overflow are single-cycle pulses
    data_d  = data_q;
    ovf_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        act_d = 2'b00;
        gnt_d = 2'b00;
        if ((bus.i_req != 2'b00) && (bus.i_ppfifo_rdy != 2'b00)) begin
          // Pointer holder wins if it asks; otherwise the only other requester.
          sel_d   = bus.i_req[rr_q] ? rr_q : ~rr_q;
          gnt_d   = sel_d ? 2'b10 : 2'b01;
          act_d   = bus.i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
          size_d  = bus.i_ppfifo_size;
          count_d = 24'd0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (bus.i_stb[sel_q]) begin
          if (count_q < size_q) begin
            stb_d   = 1'b1;
            data_d  = sel_q ? bus.i_data1 : bus.i_data0;
            count_d = count_q + 24'd1;
            if (count_q + 24'd1 == size_q) state_d = S_RELEASE;
          end else begin
            ovf_d = 1'b1;
          end
        end
        // A full buffer (including a zero-sized one) releases even without done.
        if (bus.i_done[sel_q] || (count_q == size_q)) state_d = S_RELEASE;
      end

      S_RELEASE: begin
        act_d   = 2'b00;
        gnt_d   = 2'b00;
        size_d  = 24'd0;
        rr_d    = ~sel_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_gnt         = gnt_q;
  assign bus.o_ppfifo_act  = act_q;
  assign bus.o_req_size    = size_q;
  assign bus.o_ppfifo_stb  = stb_q;
  assign bus.o_ppfifo_data = data_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_ppfifo_clk  = clk;
  assign o_dbg_state       = state_q;
  assign o_dbg_rr          = rr_q;

endmodule

// File: tb/tb_ppfifo_write_arbiter.sv
module tb_ppfifo_write_arbiter;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppfifo_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  logic [1:0] dbg_state;
  logic       dbg_rr;

  ppfifo_write_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_rr    (dbg_rr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ds_cnt  = 0;
  int ovf_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 2'b00;
    bus.i_stb   = 2'b00;
    bus.i_done  = 2'b00;
    bus.i_data0 = '0;
    bus.i_data1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // writer n strobes one word; expect_ok says whether it must appear downstream
  task automatic write_word(input int n, input logic [DW-1:0] d, input bit done, input bit expect_ok);
    bus.i_stb  = (n == 0) ? 2'b01 : 2'b10;
    bus.i_done = done ? bus.i_stb : 2'b00;
    if (n == 0) bus.i_data0 = d; else bus.i_data1 = d;
    if (expect_ok) exp_q.push_back(d);
    step();
    bus.i_stb  = 2'b00;
    bus.i_done = 2'b00;
  endtask

  // scoreboard: every downstream strobe must match the oldest expected word
  always @(negedge clk) begin
    if (bus.o_ppfifo_stb === 1'b1) begin
      ds_cnt++;
      if (exp_q.size() == 0) check("ds_unexpected_stb", 64'd1, 64'd0);
      else check("ds_data", 64'(bus.o_ppfifo_data), 64'(exp_q.pop_front()));
    end
    if (bus.o_overflow === 1'b1) ovf_cnt++;
  end

  int ds0, ovf0;

  initial begin
    idle_inputs();
    bus.i_ppfifo_rdy  = 2'b00;
    bus.i_ppfifo_size = 24'd0;
    rst = 1'b1;
    step(); step(); step();
    check("rst_gnt", 64'(bus.o_gnt), 64'd0);
    check("rst_act", 64'(bus.o_ppfifo_act), 64'd0);
    check("rst_stb", 64'(bus.o_ppfifo_stb), 64'd0);
    check("rst_data", 64'(bus.o_ppfifo_data), 64'd0);
    check("rst_size", 64'(bus.o_req_size), 64'd0);
    check("rst_ovf", 64'(bus.o_overflow), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_rr", 64'(dbg_rr), 64'd0);
    check("ppfifo_clk", 64'(bus.o_ppfifo_clk), 64'd1);
    rst = 1'b0;

    // 1: single writer, auto-release at size 4
    ds0 = ds_cnt;
    bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd4; bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    check("t1_gnt", 64'(bus.o_gnt), 64'd1);
    check("t1_act", 64'(bus.o_ppfifo_act), 64'd1);
    check("t1_size", 64'(bus.o_req_size), 64'd4);
    for (int i = 1; i <= 4; i++) write_word(0, DW'(i), 1'b0, 1'b1);
    step();
    check("t1_rel_act", 64'(bus.o_ppfifo_act), 64'd0);
    check("t1_rel_gnt", 64'(bus.o_gnt), 64'd0);
    check("t1_rel_size", 64'(bus.o_req_size), 64'd0);
    check("t1_rr", 64'(dbg_rr), 64'd1);
    check("t1_ds_cnt", 64'(ds_cnt - ds0), 64'd4);

    // 2: both request; round-robin, never interleaved
    do_reset();
    bus.i_ppfifo_rdy = 2'b11; bus.i_ppfifo_size = 24'd8; bus.i_req = 2'b11;
    step();
    bus.i_req = 2'b10;
    check("t2_gnt0", 64'(bus.o_gnt), 64'd1);
    check("t2_act0", 64'(bus.o_ppfifo_act), 64'd1);
    write_word(0, 32'hA1, 1'b0, 1'b1);
    write_word(0, 32'hA2, 1'b1, 1'b1);   // last word and done together
    step();
    check("t2_gap_gnt", 64'(bus.o_gnt), 64'd0);
    step();
    bus.i_req = 2'b00;
    check("t2_gnt1", 64'(bus.o_gnt), 64'd2);
    check("t2_act1", 64'(bus.o_ppfifo_act), 64'd1);
    write_word(0, 32'hDEAD, 1'b1, 1'b0);  // non-granted writer: ignored
    write_word(1, 32'hB1, 1'b0, 1'b1);
    write_word(1, 32'hB2, 1'b1, 1'b1);
    step();
    check("t2_end_gnt", 64'(bus.o_gnt), 64'd0);

    // 3: burst longer than buffer, auto-release, no overflow
    do_reset();
    ds0 = ds_cnt; ovf0 = ovf_cnt;
    bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd4; bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    for (int i = 0; i < 6; i++) write_word(0, 32'h31 + DW'(i), 1'b0, i < 4);
    check("t3_gnt", 64'(bus.o_gnt), 64'd0);
    check("t3_ds_cnt", 64'(ds_cnt - ds0), 64'd4);
    ds0 = ds_cnt;
    bus.i_ppfifo_size = 24'd3; bus.i_req = 2'b01;   // rr points at 1, only 0 asks
    step();
    bus.i_req = 2'b00;
    check("t3b_gnt", 64'(bus.o_gnt), 64'd1);
    for (int i = 0; i < 5; i++) write_word(0, 32'h51 + DW'(i), 1'b0, i < 3);
    check("t3b_gnt_rel", 64'(bus.o_gnt), 64'd0);
    check("t3b_ds_cnt", 64'(ds_cnt - ds0), 64'd3);
    check("t3_ovf", 64'(ovf_cnt - ovf0), 64'd0);

    // 4: writer 1 strobing while writer 0 holds buffer 1
    do_reset();
    ds0 = ds_cnt;
    bus.i_ppfifo_rdy = 2'b10; bus.i_ppfifo_size = 24'd3; bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    check("t4_act", 64'(bus.o_ppfifo_act), 64'd2);
    write_word(1, 32'hEE01, 1'b0, 1'b0);
    write_word(0, 32'h41, 1'b0, 1'b1);
    write_word(1, 32'hEE02, 1'b0, 1'b0);
    write_word(0, 32'h42, 1'b0, 1'b1);
    write_word(1, 32'hEE03, 1'b1, 1'b0);
    check("t4_still_gnt", 64'(bus.o_gnt), 64'd1);
    write_word(0, 32'h43, 1'b0, 1'b1);
    step();
    check("t4_rel_gnt", 64'(bus.o_gnt), 64'd0);
    check("t4_ds_cnt", 64'(ds_cnt - ds0), 64'd3);

    // 5: no ready buffer, then buffer 1; zero-word block
    do_reset();
    ds0 = ds_cnt;
    bus.i_ppfifo_rdy = 2'b00; bus.i_ppfifo_size = 24'd4; bus.i_req = 2'b01;
    step(); step(); step();
    check("t5_wait_gnt", 64'(bus.o_gnt), 64'd0);
    check("t5_wait_act", 64'(bus.o_ppfifo_act), 64'd0);
    bus.i_ppfifo_rdy = 2'b10;
    step();
    bus.i_req = 2'b00;
    check("t5_act", 64'(bus.o_ppfifo_act), 64'd2);
    check("t5_gnt", 64'(bus.o_gnt), 64'd1);
    bus.i_done = 2'b01;
    step();
    bus.i_done = 2'b00;
    step();
    check("t5_rel_act", 64'(bus.o_ppfifo_act), 64'd0);
    check("t5_ds_cnt", 64'(ds_cnt - ds0), 64'd0);

    // 6: reset mid-grant (rr pointer is 1 from block 5)
    bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd8; bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    check("t6_gnt", 64'(bus.o_gnt), 64'd1);
    check("t6_rr_before", 64'(dbg_rr), 64'd1);
    write_word(0, 32'h61, 1'b0, 1'b1);
    write_word(0, 32'h62, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    check("t6_act", 64'(bus.o_ppfifo_act), 64'd0);
    check("t6_gnt_rst", 64'(bus.o_gnt), 64'd0);
    check("t6_stb", 64'(bus.o_ppfifo_stb), 64'd0);
    check("t6_rr", 64'(dbg_rr), 64'd0);
    check("t6_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // 7: zero-sized buffer, strobe is dropped with an overflow pulse
    ds0 = ds_cnt;
    bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd0; bus.i_req = 2'b01;
    step();
    bus.i_req = 2'b00;
    write_word(0, 32'h77, 1'b0, 1'b0);
    check("t7_ovf", 64'(bus.o_overflow), 64'd1);
    step();
    check("t7_ovf_pulse", 64'(bus.o_overflow), 64'd0);
    check("t7_gnt", 64'(bus.o_gnt), 64'd0);
    check("t7_ds_cnt", 64'(ds_cnt - ds0), 64'd0);

    step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
